// File: rtl/fetch_queue_if.sv
// Bundle of every signal the fetch unit exchanges with instruction memory,
// the branch unit and decode. The fetch unit takes the master view; the
// environment (memory, branch resolution, decode) takes the slave view.
interface fetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Instruction memory side
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    // Branch redirect
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    // Decode side
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc_out;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output ir_valid,
        input  ir_ready,
        output ir,
        output pc_out,
        output q_count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  ir_valid,
        output ir_ready,
        input  ir,
        input  pc_out,
        input  q_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch unit with a DEPTH-entry prefetch queue.
// Keeps its own PC, issues one outstanding read at a time, pushes returned
// {pc, instr} pairs into a circular queue and hands the head to decode via
// valid/ready. A redirect flushes the queue and drops any in-flight response.
module fetch_queue #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              req_q;
    logic [ADDR_W-1:0] req_addr_q;

    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Queue storage is plain registers: the head is read combinationally and
    // every slot is cleared on reset, so a registered-read RAM does not fit.
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];

    logic              push_en;
    logic              pop_en;
    logic              has_room_after;
    logic              has_room_now;
    logic [ADDR_W-1:0] fetch_pc_inc;

    // Queue bookkeeping for this cycle; a redirect overrides both push and pop.
    always_comb begin
        push_en        = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
        pop_en         = (count_q != '0) && bus.ir_ready && !bus.redirect_valid;
        count_d        = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_en && pop_en) begin
            count_d = count_q - CNT_W'(1);
        end
        has_room_now   = count_q < CNT_W'(DEPTH);
        has_room_after = count_d < CNT_W'(DEPTH);
        fetch_pc_inc   = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    // Fetch control FSM: owns the PC and the registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            req_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    // Responses seen here belong to nobody and are ignored.
                    if (bus.redirect_valid) begin
                        fetch_pc_q <= bus.redirect_pc;
                    end else if (has_room_now) begin
                        req_q      <= 1'b1;
                        req_addr_q <= fetch_pc_q;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_q <= bus.redirect_pc;
                        req_q      <= 1'b0;
                        // A response landing this cycle is simply dropped;
                        // otherwise it is still in flight and must be drained.
                        state_q    <= bus.imem_rvalid ? IDLE : DRAIN;
                    end else if (bus.imem_rvalid) begin
                        fetch_pc_q <= fetch_pc_inc;
                        if (has_room_after) begin
                            // Back-to-back: next request goes out immediately.
                            req_addr_q <= fetch_pc_inc;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_q <= bus.redirect_pc;
                    end
                    if (bus.imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Queue storage: the pushed pc is the address the request went out on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push_en) begin
            instr_q[wr_ptr_q] <= bus.imem_rdata;
            pc_q[wr_ptr_q]    <= req_addr_q;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_addr_q;
    assign bus.ir_valid  = (count_q != '0);
    assign bus.ir        = instr_q[rd_ptr_q];
    assign bus.pc_out    = pc_q[rd_ptr_q];
    assign bus.q_count   = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-level reference model checked every cycle,
// a configurable-latency memory responder, and directed scenarios with
// hand-computed expectations. A second instance covers RESET_PC wrap.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst1;
    logic rst2;

    fetch_queue_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) bus1 ();
    fetch_queue_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) bus2 ();

    fetch_queue #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(16'h0000)
    ) dut1 (
        .clk(clk),
        .rst(rst1),
        .bus(bus1)
    );

    fetch_queue #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(16'hFFFF)
    ) dut2 (
        .clk(clk),
        .rst(rst2),
        .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] mem_word(logic [15:0] a);
        case (a)
            16'h0000: return 16'h0020;
            16'h0001: return 16'h1234;
            default:  return a ^ 16'hBEEF;
        endcase
    endfunction

    // Memory responder for dut1: latches the request address and answers
    // mem_lat cycles after it first sees the request.
    int          mem_lat = 1;
    bit          r_busy;
    int          r_cnt;
    logic [15:0] r_addr;

    initial begin
        bus1.imem_rvalid = 1'b0;
        bus1.imem_rdata  = '0;
        r_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (rst1) begin
            bus1.imem_rvalid = 1'b0;
            r_busy = 1'b0;
        end else begin
            if (bus1.imem_rvalid) begin
                bus1.imem_rvalid = 1'b0;
                r_busy = 1'b0;
            end
            if (!r_busy && bus1.imem_req) begin
                r_busy = 1'b1;
                r_cnt  = mem_lat;
                r_addr = bus1.imem_addr;
            end
            if (r_busy && r_cnt > 0) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    bus1.imem_rvalid = 1'b1;
                    bus1.imem_rdata  = mem_word(r_addr);
                end
            end
        end
    end

    // Reference model: the queue is a plain SV queue; the fetch engine is
    // described by "is a request pending" and "is its answer still wanted".
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] popped[$];
    logic [15:0] m_fetch;
    logic [15:0] m_addr;
    bit          m_pend;
    bit          m_want;
    bit          m_got;
    bit          m_pop;
    bit          m_idle;
    int          m_before;
    ent_t        m_ent;

    always @(posedge clk) begin
        if (rst1) begin
            mq.delete();
            m_fetch = 16'h0000;
            m_addr  = 16'h0000;
            m_pend  = 1'b0;
            m_want  = 1'b0;
        end else begin
            m_idle   = !m_pend;
            m_before = mq.size();
            m_got    = m_pend && bus1.imem_rvalid;
            m_pop    = (mq.size() != 0) && bus1.ir_ready;
            if (m_got) m_pend = 1'b0;
            if (bus1.redirect_valid) begin
                mq.delete();
                m_fetch = bus1.redirect_pc;
                m_want  = 1'b0;
            end else begin
                if (m_pop) begin
                    popped.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (m_got && m_want) begin
                    m_ent.pc    = m_addr;
                    m_ent.instr = bus1.imem_rdata;
                    mq.push_back(m_ent);
                    m_fetch = m_fetch + 16'd1;
                    if (mq.size() < DEPTH) begin
                        m_pend = 1'b1;
                        m_want = 1'b1;
                        m_addr = m_fetch;
                    end
                end else if (m_idle && m_before < DEPTH) begin
                    m_pend = 1'b1;
                    m_want = 1'b1;
                    m_addr = m_fetch;
                end
            end
        end
    end

    // Per-cycle comparison of dut1 against the model.
    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            chk("imem_req", bus1.imem_req, m_pend && m_want);
            if (m_pend && m_want) chk("imem_addr", bus1.imem_addr, m_addr);
            chk("ir_valid", bus1.ir_valid, mq.size() != 0);
            chk("q_count", bus1.q_count, mq.size());
            if (mq.size() != 0) begin
                chk("ir", bus1.ir, mq[0].instr);
                chk("pc_out", bus1.pc_out, mq[0].pc);
            end
        end
    end

    assign bus2.imem_rdata = bus2.imem_addr ^ 16'h5A5A;

    task automatic reset1(int lat);
        rst1 = 1'b1;
        bus1.ir_ready = 1'b0;
        bus1.redirect_valid = 1'b0;
        mem_lat = lat;
        tick(2);
        popped.delete();
        rst1 = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.ir_ready = 1'b0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc = '0;
        bus2.ir_ready = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc = '0;
        bus2.imem_rvalid = 1'b0;
        tick(1);
        checking = 1'b1;
        tick(1);

        // Reset values
        chk("rst_imem_req", bus1.imem_req, 1'b0);
        chk("rst_imem_addr", bus1.imem_addr, 16'h0000);
        chk("rst_q_count", bus1.q_count, 3'd0);
        chk("rst_ir_valid", bus1.ir_valid, 1'b0);
        chk("rst_ir", bus1.ir, 16'h0000);
        chk("rst_pc_out", bus1.pc_out, 16'h0000);

        // Reset fetch with a 1-cycle memory and a draining consumer
        mem_lat = 1;
        bus1.ir_ready = 1'b1;
        rst1 = 1'b0;
        tick(1);
        chk("t1_req_e1", bus1.imem_req, 1'b1);
        chk("t1_addr_e1", bus1.imem_addr, 16'h0000);
        tick(1);
        chk("t1_valid_e2", bus1.ir_valid, 1'b1);
        chk("t1_ir_e2", bus1.ir, 16'h0020);
        chk("t1_pc_e2", bus1.pc_out, 16'h0000);
        tick(1);
        chk("t1_ir_e3", bus1.ir, 16'h1234);
        chk("t1_pc_e3", bus1.pc_out, 16'h0001);

        // Fill under backpressure, then a single pop
        reset1(1);
        tick(5);
        chk("t2_count_full", bus1.q_count, 3'd4);
        chk("t2_req_full", bus1.imem_req, 1'b0);
        tick(3);
        chk("t2_req_hold", bus1.imem_req, 1'b0);
        chk("t2_count_hold", bus1.q_count, 3'd4);
        bus1.ir_ready = 1'b1;
        tick(1);
        bus1.ir_ready = 1'b0;
        chk("t2_count_pop", bus1.q_count, 3'd3);
        tick(1);
        chk("t2_req_refill", bus1.imem_req, 1'b1);
        chk("t2_addr_refill", bus1.imem_addr, 16'h0004);
        tick(1);

        // Steady state at 3 entries: push and pop every cycle
        bus1.ir_ready = 1'b1;
        tick(1);
        bus1.ir_ready = 1'b0;
        tick(1);
        chk("t3_count_pre", bus1.q_count, 3'd3);
        chk("t3_addr_pre", bus1.imem_addr, 16'h0005);
        bus1.ir_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t3_count_steady", bus1.q_count, 3'd3);
        end
        bus1.ir_ready = 1'b0;
        chk("t3_pop_total", popped.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_pop_order", popped[i], i);
        end
        tick(2);

        // Redirect from IDLE with a full queue
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc = 16'h0200;
        tick(1);
        bus1.redirect_valid = 1'b0;
        chk("t3_redir_count", bus1.q_count, 3'd0);
        chk("t3_redir_valid", bus1.ir_valid, 1'b0);
        tick(1);
        chk("t3_redir_req", bus1.imem_req, 1'b1);
        chk("t3_redir_addr", bus1.imem_addr, 16'h0200);
        tick(2);

        // Redirect while WAIT with a 3-cycle memory
        reset1(3);
        tick(1);
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc = 16'h0040;
        tick(1);
        bus1.redirect_valid = 1'b0;
        chk("t4_req_drain", bus1.imem_req, 1'b0);
        tick(2);
        chk("t4_req_after_stale", bus1.imem_req, 1'b0);
        chk("t4_valid_after_stale", bus1.ir_valid, 1'b0);
        tick(1);
        chk("t4_req_new", bus1.imem_req, 1'b1);
        chk("t4_addr_new", bus1.imem_addr, 16'h0040);
        bus1.ir_ready = 1'b1;
        tick(6);
        chk("t4_first_pop", popped[0], 16'h0040);

        // Second redirect arriving during DRAIN wins
        reset1(3);
        tick(1);
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc = 16'h0040;
        tick(1);
        bus1.redirect_pc = 16'h0050;
        tick(1);
        bus1.redirect_valid = 1'b0;
        tick(1);
        chk("t4b_req_idle", bus1.imem_req, 1'b0);
        tick(1);
        chk("t4b_req_new", bus1.imem_req, 1'b1);
        chk("t4b_addr_new", bus1.imem_addr, 16'h0050);

        // Redirect coinciding with rvalid and a pop
        reset1(1);
        bus1.ir_ready = 1'b1;
        tick(3);
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc = 16'h0100;
        tick(1);
        bus1.redirect_valid = 1'b0;
        chk("t5_valid_flush", bus1.ir_valid, 1'b0);
        chk("t5_count_flush", bus1.q_count, 3'd0);
        chk("t5_req_flush", bus1.imem_req, 1'b0);
        tick(1);
        chk("t5_req_new", bus1.imem_req, 1'b1);
        chk("t5_addr_new", bus1.imem_addr, 16'h0100);
        tick(1);
        chk("t5_valid_new", bus1.ir_valid, 1'b1);
        chk("t5_pc_new", bus1.pc_out, 16'h0100);

        // PC wrap and mid-WAIT reset on the RESET_PC=FFFF instance
        rst2 = 1'b0;
        bus2.imem_rvalid = 1'b1;
        tick(1);
        chk("t6_req_e1", bus2.imem_req, 1'b1);
        chk("t6_addr_e1", bus2.imem_addr, 16'hFFFF);
        tick(1);
        chk("t6_valid_e2", bus2.ir_valid, 1'b1);
        chk("t6_pc_e2", bus2.pc_out, 16'hFFFF);
        chk("t6_ir_e2", bus2.ir, 16'hA5A5);
        chk("t6_addr_wrap", bus2.imem_addr, 16'h0000);
        tick(1);
        chk("t6_count_e3", bus2.q_count, 3'd2);
        bus2.ir_ready = 1'b1;
        tick(1);
        bus2.ir_ready = 1'b0;
        chk("t6_pc_wrapped", bus2.pc_out, 16'h0000);
        chk("t6_count_e4", bus2.q_count, 3'd2);
        tick(1);
        chk("t6_req_e5", bus2.imem_req, 1'b1);
        rst2 = 1'b1;
        bus2.imem_rvalid = 1'b0;
        tick(1);
        chk("t6_rst_req", bus2.imem_req, 1'b0);
        chk("t6_rst_count", bus2.q_count, 3'd0);
        chk("t6_rst_addr", bus2.imem_addr, 16'hFFFF);
        chk("t6_rst_valid", bus2.ir_valid, 1'b0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
